// File: rtl/stim_replay_seq_if.sv
// stim_replay_seq_if: load, control and replay-output signals between harness and replay engine.
interface stim_replay_seq_if #(
    parameter int DATA_W = 31,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W:0]   ld_data;
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic              step;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] datai_o;
    logic              obs_o;
    logic              vec_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  cycles;
    logic [CNT_W-1:0]  loops;

    modport master (
        output ld_en, ld_addr, ld_data, start, stop, mode, step, len,
        input  datai_o, obs_o, vec_valid, pc, busy, done, err, cycles, loops
    );
    modport slave (
        input  ld_en, ld_addr, ld_data, start, stop, mode, step, len,
        output datai_o, obs_o, vec_valid, pc, busy, done, err, cycles, loops
    );
endinterface

// File: rtl/stim_replay_seq.sv
// stim_replay_seq: replays a RAM-held program of {obs, data} vectors into the DUT, one per clock or per step.
module stim_replay_seq #(
    parameter int DATA_W = 31,
    parameter int DEPTH  = 21,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input logic clock,
    input logic reset,
    stim_replay_seq_if.slave bus
);
    localparam logic [ADDR_W:0] DEP = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} state_t;

    state_t            state, state_nx;
    logic [DATA_W:0]   ram [DEPTH];
    logic [ADDR_W:0]   len_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  cycles, loops;
    logic [DATA_W-1:0] data_q;
    logic              obs_q, vec_valid, err, busy, done;
    logic              can_start, len_ok, start_ok, start_bad, ld_ok, ld_bad, issue, last;

    // stop outranks every command, so a start paired with stop is never seen
    assign can_start = (state == IDLE || state == DONE) && bus.start && !bus.stop;
    assign len_ok    = bus.len != '0 && bus.len <= DEP;
    assign start_ok  = can_start && len_ok;
    assign start_bad = can_start && !len_ok;
    assign ld_ok     = bus.ld_en && !busy && {1'b0, bus.ld_addr} < DEP;
    assign ld_bad    = bus.ld_en && !ld_ok;
    assign issue     = !bus.stop && (state == RUN || (state == STEP && bus.step));
    assign last      = {1'b0, pc} == len_q - (ADDR_W+1)'(1);

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        if (bus.stop && state != IDLE)
            state_nx = IDLE;
        else if (start_ok)
            state_nx = (bus.mode == 2'b10) ? STEP : RUN;
        else if (issue && last && mode_q != 2'b01)
            state_nx = DONE;
    end

    always_comb begin
        busy = state == RUN || state == STEP;
        done = state == DONE;
    end

    // RAM is deliberately left out of reset
    always_ff @(posedge clock)
        if (ld_ok) ram[bus.ld_addr] <= bus.ld_data;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            len_q     <= '0;
            mode_q    <= '0;
            pc        <= '0;
            cycles    <= '0;
            loops     <= '0;
            data_q    <= '0;
            obs_q     <= 1'b0;
            vec_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err       <= start_bad || ld_bad;
            vec_valid <= issue;
            if (start_ok) begin
                len_q  <= bus.len;
                mode_q <= bus.mode;
                pc     <= '0;
                cycles <= '0;
                loops  <= '0;
            end else if (issue) begin
                {obs_q, data_q} <= ram[pc];
                pc              <= last ? '0 : pc + ADDR_W'(1);
                cycles          <= &cycles ? cycles : cycles + CNT_W'(1);
                if (last && mode_q == 2'b01 && state == RUN)
                    loops <= &loops ? loops : loops + CNT_W'(1);
            end
        end

    assign bus.datai_o   = data_q;
    assign bus.obs_o     = obs_q;
    assign bus.vec_valid = vec_valid;
    assign bus.pc        = pc;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err;
    assign bus.cycles    = cycles;
    assign bus.loops     = loops;
endmodule
